// File: rtl/pc_exc_pkg.sv
// Shared types and constants for the PC / exception stage.
package pc_exc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRead = 2'b01,
    StLoad = 2'b10
  } exc_state_e;

  typedef enum logic [1:0] {
    CauseOpcode = 2'b00,
    CauseOvf    = 2'b01,
    CauseDiv0   = 2'b10,
    CauseRsvd   = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    PcSrcAluResult = 2'b00,
    PcSrcAluOut    = 2'b01,
    PcSrcJump      = 2'b10,
    PcSrcEpc       = 2'b11
  } pc_src_e;

  localparam logic [31:0] DefVecOpcode = 32'd255;
  localparam logic [31:0] DefVecOvf    = 32'd254;
  localparam logic [31:0] DefVecDiv0   = 32'd253;

  // The reserved cause code is handled as an invalid opcode.
  function automatic exc_cause_e norm_cause(input logic [1:0] cause);
    return (cause == 2'b11) ? CauseOpcode : exc_cause_e'(cause);
  endfunction

endpackage

// File: rtl/pc_exc_fsm.sv
// Exception-entry sequencer: latches the cause, reads the vector byte, then requests the PC load.
module pc_exc_fsm
  import pc_exc_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = DefVecOpcode,
  parameter logic [31:0] VEC_OVF    = DefVecOvf,
  parameter logic [31:0] VEC_DIV0   = DefVecDiv0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_exc_req,
  input  logic [1:0]  i_exc_cause,
  output logic [31:0] o_exc_mem_addr,
  output logic        o_exc_mem_rd,
  output logic        o_exc_busy,
  output logic        o_exc_done,
  output logic        o_enter,
  output logic        o_load
);

  exc_state_e r_state, w_state_nxt;
  exc_cause_e r_cause, w_cause_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [31:0] w_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cause <= CauseOpcode;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_exc_req) begin
          w_state_nxt = StRead;
          w_cause_nxt = norm_cause(i_exc_cause);
          w_cnt_nxt   = 3'(MEM_LAT);
        end
      end
      StRead: begin
        if (r_cnt <= 3'd1) begin
          w_state_nxt = StLoad;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      StLoad:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_vec = VEC_OPCODE;
    unique case (r_cause)
      CauseOvf:  w_vec = VEC_OVF;
      CauseDiv0: w_vec = VEC_DIV0;
      default:   w_vec = VEC_OPCODE;
    endcase
  end

  assign o_exc_mem_addr = (r_state == StIdle) ? 32'd0 : w_vec;
  assign o_exc_mem_rd   = (r_state == StRead);
  assign o_exc_done     = (r_state == StLoad);
  assign o_exc_busy     = (r_state != StIdle);
  assign o_enter        = (r_state == StIdle) && i_exc_req;
  assign o_load         = (r_state == StLoad);

endmodule

// File: rtl/pc_exception_unit.sv
// Architectural PC/EPC registers with next-PC selection and exception entry.
module pc_exception_unit
  import pc_exc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = DefVecOpcode,
  parameter logic [31:0] VEC_OVF    = DefVecOvf,
  parameter logic [31:0] VEC_DIV0   = DefVecDiv0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [25:0] jump_index,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] exc_mem_addr,
  output logic        exc_mem_rd,
  output logic        exc_busy,
  output logic        exc_done
);

  logic [31:0] r_pc, r_epc;
  logic [31:0] w_pc_sel;
  logic        w_taken, w_enter, w_load;

  pc_exc_fsm #(
    .MEM_LAT   (MEM_LAT),
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVF   (VEC_OVF),
    .VEC_DIV0  (VEC_DIV0)
  ) u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_exc_req     (exc_req),
    .i_exc_cause   (exc_cause),
    .o_exc_mem_addr(exc_mem_addr),
    .o_exc_mem_rd  (exc_mem_rd),
    .o_exc_busy    (exc_busy),
    .o_exc_done    (exc_done),
    .o_enter       (w_enter),
    .o_load        (w_load)
  );

  assign w_taken = pc_write_cond && (alu_zero ^ branch_ne);

  always_comb begin
    w_pc_sel = alu_result;
    unique case (pc_src_e'(pc_src))
      PcSrcAluResult: w_pc_sel = alu_result;
      PcSrcAluOut:    w_pc_sel = alu_out;
      PcSrcJump:      w_pc_sel = {r_pc[31:28], jump_index, 2'b00};
      PcSrcEpc:       w_pc_sel = r_epc;
    endcase
  end

  // Exception entry outranks normal writes; busy cycles only allow the vector load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_epc <= 32'd0;
    end else if (w_load) begin
      r_pc <= {24'b0, mem_rdata};
    end else if (w_enter) begin
      r_epc <= r_pc - 32'd4;
    end else if (!exc_busy && (pc_write || w_taken)) begin
      r_pc <= w_pc_sel;
    end
  end

  assign pc  = r_pc;
  assign epc = r_epc;

endmodule

// File: tb/tb_pc_exception_unit.sv
// Directed and randomized checks of pc_exception_unit at MEM_LAT 1 and 3 against a cycle model.
module tb_pc_exception_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_write, pc_write_cond, branch_ne, alu_zero;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, alu_out;
  logic [25:0] jump_index;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [7:0]  mem_rdata;

  logic [31:0] pc0, epc0, addr0, pc1, epc1, addr1;
  logic        rd0, busy0, done0, rd1, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: rem = busy cycles still to come (0 idle, 1 the load cycle).
  logic [31:0] m_pc[2];
  logic [31:0] m_epc[2];
  logic [1:0]  m_cause[2];
  int          m_rem[2];

  pc_exception_unit #(.RESET_PC(32'd0), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .pc_src(pc_src), .alu_result(alu_result),
    .alu_out(alu_out), .jump_index(jump_index), .exc_req(exc_req), .exc_cause(exc_cause),
    .mem_rdata(mem_rdata), .pc(pc0), .epc(epc0), .exc_mem_addr(addr0), .exc_mem_rd(rd0),
    .exc_busy(busy0), .exc_done(done0)
  );

  pc_exception_unit #(.RESET_PC(32'd0), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .pc_src(pc_src), .alu_result(alu_result),
    .alu_out(alu_out), .jump_index(jump_index), .exc_req(exc_req), .exc_cause(exc_cause),
    .mem_rdata(mem_rdata), .pc(pc1), .epc(epc1), .exc_mem_addr(addr1), .exc_mem_rd(rd1),
    .exc_busy(busy1), .exc_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] vec_of(input logic [1:0] c);
    case (c)
      2'd1:    return 32'd254;
      2'd2:    return 32'd253;
      default: return 32'd255;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'd0; m_epc[i] = 32'd0; m_cause[i] = 2'd0; m_rem[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      if (m_rem[i] == 0) begin
        if (exc_req) begin
          m_epc[i]   = m_pc[i] - 32'd4;
          m_cause[i] = (exc_cause == 2'b11) ? 2'b00 : exc_cause;
          m_rem[i]   = lat + 1;
        end else if (pc_write || (pc_write_cond && (alu_zero != branch_ne))) begin
          case (pc_src)
            2'd0: m_pc[i] = alu_result;
            2'd1: m_pc[i] = alu_out;
            2'd2: m_pc[i] = {m_pc[i][31:28], jump_index, 2'b00};
            default: m_pc[i] = m_epc[i];
          endcase
        end
      end else begin
        if (m_rem[i] == 1) m_pc[i] = {24'd0, mem_rdata};
        m_rem[i] = m_rem[i] - 1;
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic [31:0] p, input logic [31:0] e,
                          input logic [31:0] a, input logic r, input logic b, input logic d);
    chk($sformatf("pc%0d", i), p, m_pc[i]);
    chk($sformatf("epc%0d", i), e, m_epc[i]);
    chk($sformatf("addr%0d", i), a, (m_rem[i] != 0) ? vec_of(m_cause[i]) : 32'd0);
    chk($sformatf("rd%0d", i), {31'd0, r}, {31'd0, (m_rem[i] > 1)});
    chk($sformatf("busy%0d", i), {31'd0, b}, {31'd0, (m_rem[i] != 0)});
    chk($sformatf("done%0d", i), {31'd0, d}, {31'd0, (m_rem[i] == 1)});
  endtask

  task automatic check_model();
    chk_inst(0, pc0, epc0, addr0, rd0, busy0, done0);
    chk_inst(1, pc1, epc1, addr1, rd1, busy1, done1);
  endtask

  // Inputs change at the falling edge; the model steps with the DUT at the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; branch_ne = 0; alu_zero = 0; pc_src = 2'd0;
    alu_result = 32'd0; alu_out = 32'd0; jump_index = 26'd0; exc_req = 0;
    exc_cause = 2'd0; mem_rdata = 8'd0;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    chk("rst_pc", pc0, 32'd0);
    chk("rst_epc", epc0, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Unconditional write
    pc_write = 1; pc_src = 2'd0; alu_result = 32'h4;
    cycle();
    chk("pc_write", pc0, 32'h4);
    chk("pc_write_epc", epc0, 32'd0);

    // Conditional branches
    alu_result = 32'h40;
    cycle();
    pc_write = 0; pc_write_cond = 1; branch_ne = 0; alu_zero = 0; pc_src = 2'd1;
    alu_out = 32'h80;
    cycle();
    chk("beq_not_taken", pc0, 32'h40);
    alu_zero = 1;
    cycle();
    chk("beq_taken", pc0, 32'h80);
    branch_ne = 1; alu_zero = 0; alu_out = 32'h100;
    cycle();
    chk("bne_taken", pc1, 32'h100);

    // Jump keeps upper PC nibble
    pc_write_cond = 0; pc_write = 1; pc_src = 2'd0; alu_result = 32'hA000_0010;
    cycle();
    pc_src = 2'd2; jump_index = 26'h3;
    cycle();
    chk("jump", pc0, 32'hA000_000C);

    // Exception wins over a simultaneous pc_write, MEM_LAT=1 timing
    pc_src = 2'd0; alu_result = 32'h24;
    cycle();
    exc_req = 1; exc_cause = 2'b01; alu_result = 32'h1234; mem_rdata = 8'h9C;
    cycle();
    chk("exc_epc", epc0, 32'h20);
    chk("exc_addr", addr0, 32'd254);
    chk("exc_rd", {31'd0, rd0}, 32'd1);
    chk("exc_pc_hold", pc0, 32'h24);
    exc_req = 0;
    cycle();
    chk("exc_done", {31'd0, done0}, 32'd1);
    cycle();
    chk("exc_load", pc0, 32'h9C);
    chk("exc_idle", {31'd0, busy0}, 32'd0);
    pc_write = 0;
    repeat (3) cycle();

    // MEM_LAT=3, reserved cause maps to opcode vector
    exc_req = 1; exc_cause = 2'b11; mem_rdata = 8'h5A;
    cycle();
    exc_req = 0;
    chk("lat3_addr", addr1, 32'd255);
    chk("lat3_epc", epc1, 32'h98);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy1) busy_cnt++;
      if (done1) done_cnt++;
      cycle();
    end
    chk("lat3_busy_cycles", busy_cnt, 32'd4);
    chk("lat3_done_pulses", done_cnt, 32'd1);
    chk("lat3_load", pc1, 32'h5A);
    pc_write = 1; pc_src = 2'd3;
    cycle();
    chk("eret", pc1, 32'h98);
    pc_write = 0;
    cycle();

    // Asynchronous reset during READ
    exc_req = 1; exc_cause = 2'b10; mem_rdata = 8'h77;
    cycle();
    exc_req = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pc", pc1, 32'd0);
    chk("arst_epc", epc1, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("arst_no_load", pc1, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = ($urandom_range(0, 1) == 0);
      branch_ne     = 1'($urandom);
      alu_zero      = 1'($urandom);
      pc_src        = 2'($urandom);
      alu_result    = $urandom;
      alu_out       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      jump_index    = 26'($urandom);
      exc_req       = ($urandom_range(0, 5) == 0);
      exc_cause     = 2'($urandom);
      mem_rdata     = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_exception_unit.md
# pc_exception_unit

Program-counter stage of the multicycle datapath. Holds the architectural PC and EPC and applies normal PC updates: unconditional, conditional branch, jump and return-from-exception. Runs a short sequencer that enters an exception: save EPC, fetch the handler byte from the vector table in memory, load it into PC. Its `pc` output drives the PC input of the ALU operand-A selector and the memory-address selector.

## Interface
Parameters:
- `RESET_PC`, 32'd0: PC value after reset.
- `MEM_LAT`, 1: memory read latency in cycles (1..7).
- `VEC_OPCODE`, 32'd255: vector byte address for invalid opcode.
- `VEC_OVF`, 32'd254: vector byte address for overflow.
- `VEC_DIV0`, 32'd253: vector byte address for divide-by-zero.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc_write`  in  1  unconditional PC update.
- `pc_write_cond`  in  1  conditional (branch) PC update.
- `branch_ne`  in  1  0 = take branch when `alu_zero`=1; 1 = take branch when `alu_zero`=0.
- `alu_zero`  in  1  ALU zero flag.
- `pc_src`  in  2  next-PC source: 00 `alu_result`, 01 `alu_out`, 10 jump target, 11 `epc`.
- `alu_result`  in  32  combinational ALU result.
- `alu_out`  in  32  registered ALU output.
- `jump_index`  in  26  instruction index field.
- `exc_req`  in  1  exception request, level, sampled in IDLE only.
- `exc_cause`  in  2  cause: 00 opcode, 01 overflow, 10 div0, 11 treated as 00.
- `mem_rdata`  in  8  byte returned by memory.
- `pc`  out  32  current PC.
- `epc`  out  32  exception PC.
- `exc_mem_addr`  out  32  vector address; 0 when idle.
- `exc_mem_rd`  out  1  memory read request from the sequencer.
- `exc_busy`  out  1  sequencer active (state != IDLE).
- `exc_done`  out  1  one-cycle pulse in LOAD.

## Operation
- Jump target: `{pc[31:28], jump_index, 2'b00}`, using the current `pc`.
- Branch taken: `pc_write_cond & (alu_zero ^ branch_ne)`.
- IDLE:
  - `exc_req`=1 takes priority over all writes.
  - Otherwise, if `pc_write` or a taken branch, `pc` <= source selected by `pc_src`.
  - Unaligned values are stored as-is.
- Exception entry, at the IDLE edge with `exc_req`=1:
  - `epc` <= `pc` - 4, modulo 2^32 (pc=0 gives 32'hFFFFFFFC).
  - Latch the cause; load counter = `MEM_LAT`; go to READ.
- READ:
  - `exc_mem_rd`=1; `exc_mem_addr` = vector for the latched cause.
  - Counter decrements each cycle; go to LOAD when it reaches 1.
- LOAD:
  - `exc_mem_addr` held; `exc_mem_rd`=0; `exc_done`=1.
  - At the edge, `pc` <= `{24'b0, mem_rdata}`; go to IDLE.
- While busy:
  - `pc_write`, `pc_write_cond` and `exc_req` are ignored.
  - `pc` and `epc` hold, apart from the LOAD update.
- A new `exc_req` still high in the first IDLE cycle after LOAD starts a new sequence; the current `pc` is saved.

## Timing
- Reset (async assert): `pc`=`RESET_PC`, `epc`=0, state IDLE, `exc_mem_rd`=0, `exc_mem_addr`=0, `exc_busy`=0, `exc_done`=0.
- Reset mid-sequence aborts with the same values; the partially saved EPC is cleared to 0.
- Normal update latency: 1 edge; new `pc` is visible in the cycle after the write.
- Exception latency with `MEM_LAT`=1:
  - `exc_req` seen in cycle 0.
  - READ in cycle 1; LOAD in cycle 2.
  - New `pc` in cycle 3; `exc_busy` high in cycles 1–2.
- In general: READ lasts `MEM_LAT` cycles; total busy time is `MEM_LAT`+1 cycles.
- `mem_rdata` is sampled only at the LOAD edge.

## Structure
- Package `pc_exc_pkg`:
  - state enum (IDLE, READ, LOAD);
  - cause codes;
  - `pc_src` encodings;
  - default vector constants.
- Natural sub-module: `pc_exc_fsm`, holding the state, counter, cause latch, vector address, `exc_mem_rd`, `exc_done` and `exc_busy`.
- The top level holds the `pc`/`epc` registers and the next-PC selection.

## Test plan
- Reset then `pc_write`=1, `pc_src`=00, `alu_result`=32'h4 -> `pc`=4 next cycle; `epc`=0.
- `pc`=32'h40, `pc_write_cond`=1, `branch_ne`=0, `alu_zero`=0, `alu_out`=32'h80 -> `pc` stays 32'h40. Then `alu_zero`=1 -> `pc`=32'h80. Then `branch_ne`=1, `alu_zero`=0 -> taken.
- `pc`=32'hA000_0010, `pc_src`=10, `jump_index`=26'h3 -> `pc`=32'hA000_000C.
- `pc`=32'h24, `exc_req`=1 with `exc_cause`=01 and `pc_write`=1 in the same cycle:
  - `epc`=32'h20;
  - `exc_mem_addr`=254 with `exc_mem_rd`=1 in cycle 1;
  - `mem_rdata`=8'h9C -> `pc`=32'h9C in cycle 3;
  - `pc_write` ignored.
- `MEM_LAT`=3, `exc_cause`=11 -> address 255; `exc_busy` high 4 cycles; `exc_done` pulses once. Then `pc_src`=11 with `pc_write` -> `pc`=`epc`.
- `rst_n` low during READ -> `pc`=`RESET_PC`, `epc`=0, `exc_busy`=0 immediately; no PC load after release.
